eth_tx_pkt_arbiter: RTL and testbench

ETH_TX_PKT_ARBITER -- requirements
Module: eth_tx_pkt_arbiter

---
 rtl/eth_arb_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 23 ++
 rtl/eth_tx_pkt_arbiter.sv | 152 +++++++++++++++
 tb/tb_eth_tx_pkt_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared FSM state type and round-robin pick helper for the TX packet arbiter
package eth_arb_pkg;

   localparam int MAX_NICS  = 8;
   localparam int MAX_IDX_W = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

   // One-hot pick of the first requester after 'last', wrapping modulo n.
   function automatic logic [MAX_NICS-1:0] rr_pick(
      input logic [MAX_NICS-1:0]  req,
      input logic [MAX_IDX_W-1:0] last,
      input int                   n
   );
      logic [MAX_NICS-1:0]  g;
      logic                 found;
      int                   idx;
      logic [MAX_IDX_W-1:0] idx_s;
      g     = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_NICS; k++) begin
         idx   = (int'(last) + k) % n;
         idx_s = idx[MAX_IDX_W-1:0];
         if (k <= n && !found && req[idx_s]) begin
            g[idx_s] = 1'b1;
            found    = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin search over NUM_REQ requesters starting after the last winner
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic               valid
);
   import eth_arb_pkg::*;

   logic [MAX_NICS-1:0] req_w;
   logic [MAX_NICS-1:0] pick;
   logic                unused_pick;

   assign req_w       = MAX_NICS'(req);
   assign pick        = rr_pick(req_w, MAX_IDX_W'(last), NUM_REQ);
   assign grant       = pick[NUM_REQ-1:0];
   assign valid       = |req;
   assign unused_pick = ^pick;

endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// rtl/eth_tx_pkt_arbiter.sv - packet-granular round-robin merge of NIC TX streams into one registered output
module eth_tx_pkt_arbiter #(
   parameter  int NUM_NICS    = 3,
   parameter  int DATA_WIDTH  = 256,
   parameter  int EMPTY_WIDTH = 5,
   parameter  int CNT_WIDTH   = 32,
   localparam int IDX_W       = $clog2(NUM_NICS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_NICS-1:0]             in_valid,
   input  logic [NUM_NICS-1:0]             in_sop,
   input  logic [NUM_NICS-1:0]             in_eop,
   input  logic [NUM_NICS-1:0]             in_error,
   input  logic [NUM_NICS*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_NICS*EMPTY_WIDTH-1:0] in_empty,
   output logic [NUM_NICS-1:0]             in_ready,
   output logic                            out_valid,
   output logic                            out_sop,
   output logic                            out_eop,
   output logic                            out_error,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [EMPTY_WIDTH-1:0]          out_empty,
   input  logic                            out_ready,
   output logic [IDX_W-1:0]                grant_idx,
   output logic                            grant_active,
   output logic [NUM_NICS*CNT_WIDTH-1:0]   pkt_cnt,
   output logic [CNT_WIDTH-1:0]            drop_cnt
);
   import eth_arb_pkg::*;

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       last_grant_q, grant_q;
   logic [IDX_W-1:0]       sel_idx, cand_idx, orph_idx;
   logic [NUM_NICS-1:0]    cand_grant;
   logic                   cand_valid, orph_valid, slot_free, fwd, drop, sel_eop;
   logic                   sel_sop, sel_err;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [EMPTY_WIDTH-1:0] sel_empty;
   logic [CNT_WIDTH-1:0]   pkt_cnt_q [NUM_NICS];

   rr_arbiter #(.NUM_REQ(NUM_NICS), .IDX_W(IDX_W)) u_rr (
      .req   (in_valid & in_sop),
      .last  (last_grant_q),
      .grant (cand_grant),
      .valid (cand_valid)
   );

   assign slot_free = !out_valid || out_ready;

   // Descending scan so the lowest-index orphan wins.
   always_comb begin
      cand_idx   = '0;
      orph_idx   = '0;
      orph_valid = 1'b0;
      for (int i = NUM_NICS - 1; i >= 0; i--) begin
         if (cand_grant[i]) cand_idx = IDX_W'(i);
         if (in_valid[i] && !in_sop[i]) begin
            orph_idx   = IDX_W'(i);
            orph_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = '0;
      sel_idx  = grant_q;
      drop     = 1'b0;
      fwd      = 1'b0;
      sel_eop  = 1'b0;
      if (!reset) begin
         unique case (state_q)
            ST_IDLE: begin
               if (cand_valid) begin
                  sel_idx  = cand_idx;
                  in_ready = slot_free ? cand_grant : '0;
               end else if (orph_valid) begin
                  sel_idx            = orph_idx;
                  in_ready[orph_idx] = slot_free;
                  drop               = slot_free;
               end
            end
            ST_LOCKED: in_ready[grant_q] = slot_free;
         endcase
         for (int i = 0; i < NUM_NICS; i++)
            if (sel_idx == IDX_W'(i)) sel_eop = in_eop[i];
         fwd = (|(in_valid & in_ready)) && !drop;
         if (fwd && state_q == ST_IDLE && !sel_eop) state_d = ST_LOCKED;
         if (fwd && state_q == ST_LOCKED && sel_eop) state_d = ST_IDLE;
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_empty = '0;
      sel_sop   = 1'b0;
      sel_err   = 1'b0;
      for (int i = 0; i < NUM_NICS; i++) begin
         if (sel_idx == IDX_W'(i)) begin
            sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_empty = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            sel_sop   = in_sop[i];
            sel_err   = in_error[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDX_W'(NUM_NICS - 1);
         grant_q      <= '0;
         out_valid    <= 1'b0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         out_error    <= 1'b0;
         out_data     <= '0;
         out_empty    <= '0;
         drop_cnt     <= '0;
         for (int i = 0; i < NUM_NICS; i++) pkt_cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (fwd) begin
            out_valid <= 1'b1;
            out_sop   <= sel_sop;
            out_eop   <= sel_eop;
            out_error <= sel_err;
            out_data  <= sel_data;
            out_empty <= sel_empty;
            if (state_q == ST_IDLE) begin
               last_grant_q <= sel_idx;
               if (!sel_eop) grant_q <= sel_idx;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         for (int i = 0; i < NUM_NICS; i++)
            if (fwd && sel_eop && sel_idx == IDX_W'(i))
               pkt_cnt_q[i] <= pkt_cnt_q[i] + CNT_WIDTH'(1);
         if (drop) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
   end

   assign grant_idx    = grant_q;
   assign grant_active = (state_q == ST_LOCKED);

   for (genvar g = 0; g < NUM_NICS; g++) begin : g_cnt
      assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
   end

endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb/tb_eth_tx_pkt_arbiter.sv - directed scoreboard bench for eth_tx_pkt_arbiter
module tb_eth_tx_pkt_arbiter;
   localparam int NN = 3;
   localparam int DW = 256;
   localparam int EW = 5;
   localparam int CW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic          err;
      logic [EW-1:0] empty;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NN-1:0]     in_valid = '0, in_sop = '0, in_eop = '0, in_error = '0;
   logic [NN*DW-1:0]  in_data = '0;
   logic [NN*EW-1:0]  in_empty = '0;
   logic [NN-1:0]     in_ready;
   logic              out_valid, out_sop, out_eop, out_error;
   logic [DW-1:0]     out_data;
   logic [EW-1:0]     out_empty;
   logic              out_ready = 1'b1;
   logic [1:0]        grant_idx;
   logic              grant_active;
   logic [NN*CW-1:0]  pkt_cnt;
   logic [CW-1:0]     drop_cnt;

   eth_tx_pkt_arbiter #(.NUM_NICS(NN), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_error(in_error), .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
      .out_data(out_data), .out_empty(out_empty), .out_ready(out_ready),
      .grant_idx(grant_idx), .grant_active(grant_active), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   beat_t         src_q [NN][$];
   beat_t         exp_q [$];
   int            checks = 0;
   int            passes = 0;
   logic [NN-1:0] rdy_s;
   logic          lock_chk = 1'b0;
   logic          hold_pending = 1'b0;
   beat_t         held;
   int            cyc;

   function automatic beat_t mk(input int nic, input int pkt, input int b, input int n);
      beat_t r;
      r.data          = '0;
      r.data[23:0]    = {8'(nic), 8'(pkt), 8'(b)};
      r.data[DW-1 -: 8] = 8'(8'hA0 + nic);
      r.sop           = (b == 0);
      r.eop           = (b == n - 1);
      r.err           = r.eop && ((pkt % 2) == 1);
      r.empty         = r.eop ? EW'(pkt + nic + 1) : '0;
      return r;
   endfunction

   function automatic beat_t out_beat();
      return {out_data, out_sop, out_eop, out_error, out_empty};
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic add_pkt(input int nic, input int pkt, input int n, input bit expect_it);
      for (int b = 0; b < n; b++) begin
         src_q[nic].push_back(mk(nic, pkt, b, n));
         if (expect_it) exp_q.push_back(mk(nic, pkt, b, n));
      end
   endtask

   task automatic step(input logic rst, input logic ordy);
      beat_t b;
      @(negedge clk);
      reset     = rst;
      out_ready = ordy;
      for (int i = 0; i < NN; i++) begin
         b           = (src_q[i].size() > 0) ? src_q[i][0] : '0;
         in_valid[i] = (src_q[i].size() > 0);
         in_sop[i]   = b.sop;
         in_eop[i]   = b.eop;
         in_error[i] = b.err;
         in_data[i*DW +: DW]  = b.data;
         in_empty[i*EW +: EW] = b.empty;
      end
      #1;
      rdy_s = in_ready;
      if (rst) chk("ready_low_in_reset", 512'(in_ready), 512'(0));
      if (out_valid && !out_ready) chk("ready_low_when_stalled", 512'(in_ready), 512'(0));
      if (hold_pending) chk("out_stable_while_stalled", 512'(out_beat()), 512'(held));
      if (lock_chk) chk("other_ready_low_locked", 512'(in_ready & 3'b101), 512'(0));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out_valid", 512'(out_valid), 512'(0));
         else chk("out_beat", 512'(out_beat()), 512'(exp_q.pop_front()));
      end
      hold_pending = out_valid && !out_ready && !rst;
      held         = out_beat();
      @(posedge clk);
      for (int i = 0; i < NN; i++)
         if (in_valid[i] && rdy_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (lock_chk && src_q[1].size() == 0) lock_chk = 1'b0;
   endtask

   task automatic drain(input int budget, input bit toggle, output int cycles);
      logic ordy;
      ordy   = 1'b1;
      cycles = 0;
      while (exp_q.size() > 0 && cycles < budget) begin
         step(1'b0, ordy);
         cycles++;
         if (toggle) ordy = !ordy;
      end
      chk("drain_complete", 512'(exp_q.size()), 512'(0));
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NN; i++) src_q[i].delete();
      exp_q.delete();
      lock_chk     = 1'b0;
      hold_pending = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      #1;
      chk("rst_out_valid", 512'(out_valid), 512'(0));
      chk("rst_out_fields", 512'(out_beat()), 512'(0));
      chk("rst_grant", 512'({grant_active, grant_idx}), 512'(0));
      chk("rst_counters", 512'({pkt_cnt, drop_cnt}), 512'(0));
   endtask

   initial begin
      // Three NICs with simultaneous 3-beat packets: NIC0, NIC1, NIC2, back to back.
      do_reset();
      add_pkt(0, 1, 3, 1'b1);
      add_pkt(1, 2, 3, 1'b1);
      add_pkt(2, 3, 3, 1'b1);
      drain(40, 1'b0, cyc);
      chk("three_pkt_contiguous_cycles", 512'(cyc), 512'(10));
      chk("three_pkt_cnt", 512'(pkt_cnt), 512'(12'h111));

      // 4-beat NIC1 packet with out_ready toggling; NIC0 waits behind it.
      do_reset();
      add_pkt(1, 4, 4, 1'b1);
      step(1'b0, 1'b1);
      add_pkt(0, 5, 2, 1'b1);
      lock_chk = 1'b1;
      drain(40, 1'b1, cyc);
      chk("toggle_pkt_cnt", 512'(pkt_cnt), 512'(12'h011));

      // Continuous single-beat NIC2 packets; NIC0 joins and grants alternate without gaps.
      do_reset();
      add_pkt(2, 0, 1, 1'b0);
      add_pkt(2, 1, 1, 1'b0);
      add_pkt(2, 2, 1, 1'b0);
      add_pkt(2, 3, 1, 1'b0);
      exp_q.push_back(mk(2, 0, 0, 1));
      exp_q.push_back(mk(0, 6, 0, 1));
      exp_q.push_back(mk(2, 1, 0, 1));
      exp_q.push_back(mk(0, 7, 0, 1));
      exp_q.push_back(mk(2, 2, 0, 1));
      exp_q.push_back(mk(2, 3, 0, 1));
      step(1'b0, 1'b1);
      add_pkt(0, 6, 1, 1'b0);
      add_pkt(0, 7, 1, 1'b0);
      drain(40, 1'b0, cyc);
      chk("alternate_no_idle_cycles", 512'(cyc), 512'(6));
      chk("alternate_pkt_cnt", 512'(pkt_cnt), 512'(12'h402));

      // Orphan beat in IDLE is consumed and dropped.
      do_reset();
      src_q[0].push_back(mk(0, 9, 1, 3));
      step(1'b0, 1'b1);
      chk("orphan_ready", 512'(rdy_s), 512'(3'b001));
      #1;
      chk("orphan_not_forwarded", 512'(out_valid), 512'(0));
      chk("orphan_drop_cnt", 512'(drop_cnt), 512'(1));
      step(1'b0, 1'b1);
      #1;
      chk("orphan_still_no_output", 512'(out_valid), 512'(0));
      chk("orphan_pkt_cnt", 512'(pkt_cnt), 512'(0));

      // Reset during a 5-beat NIC1 packet abandons it; the next NIC0 packet is intact.
      do_reset();
      add_pkt(1, 10, 5, 1'b0);
      exp_q.push_back(mk(1, 10, 0, 5));
      exp_q.push_back(mk(1, 10, 1, 5));
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      #1;
      chk("midpkt_rst_out_valid", 512'(out_valid), 512'(0));
      chk("midpkt_rst_state", 512'({grant_active, pkt_cnt, drop_cnt}), 512'(0));
      chk("midpkt_rst_consumed", 512'(exp_q.size()), 512'(0));
      src_q[1].delete();
      add_pkt(0, 11, 3, 1'b1);
      drain(40, 1'b0, cyc);
      chk("after_rst_pkt_cnt", 512'(pkt_cnt), 512'(12'h001));

      // 17 packets from NIC0 wrap the 4-bit counter to 1.
      do_reset();
      for (int p = 0; p < 17; p++) add_pkt(0, p, 1, 1'b1);
      drain(60, 1'b0, cyc);
      chk("wrap_pkt_cnt0", 512'(pkt_cnt), 512'(12'h001));

      for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
      #1;
      chk("final_idle_out_valid", 512'(out_valid), 512'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
